data_mem_lsu: RTL and testbench
===============================

Name: data_mem_lsu

Overview:
- Parametrised successor to the core's single-port data memory.
- Adds RV32 load/store sizes (byte/half/word), sign or zero extension, byte-lane write masking, and misalignment and out-of-range error reporting.
- Adds a request/grant/response handshake with configurable wait states.
- Sits between the core's memory stage and the word-organised storage array; one transaction is outstanding at a time.

Parameters:
- ADDR_W, 20, byte-address width.
- DATA_W, 32, data width; fixed at 32 for this revision; any other value is an elaboration error.
- DEPTH_WORDS, 1024, number of 32-bit words implemented.
- WAIT_STATES, 0, extra cycles between accept and response (0..15).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_i  input  1  request valid.
- we_i  input  1  1 = store, 0 = load.
- addr_i  input  ADDR_W  byte address.
- size_i  input  2  00 byte, 01 half, 10 word; 11 is illegal.
- unsigned_i  input  1  loads only: 1 = zero-extend (LBU/LHU), 0 = sign-extend.
- wdata_i  input  DATA_W  store data, right-justified.
- gnt_o  output  1  request accepted this cycle.
- rvalid_o  output  1  response valid for one cycle.
- rdata_o  output  DATA_W  load result, extended; 0 for stores and errors.
- err_o  output  1  qualifies rvalid_o: misaligned, out-of-range or illegal size.

Behaviour:
- Reset: state=IDLE, gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, wait counter=0. Memory contents are not reset and are preserved across reset.
- FSM IDLE -> (WAIT if WAIT_STATES>0) -> RESP -> IDLE.
- gnt_o = req_i && state==IDLE (combinational). On the accept edge, addr, we, size, unsigned and wdata are latched.
- WAIT: counter loads WAIT_STATES-1 on accept and decrements each cycle; when counter==0 the FSM moves to RESP.
- Latency: accept on cycle N -> rvalid_o high in cycle N+1+WAIT_STATES, for exactly one cycle. Back-to-back peak throughput is one transaction per 2+WAIT_STATES cycles; next gnt_o is possible in the cycle after rvalid_o.
- Word index = addr[ADDR_W-1:2]. Out-of-range when index >= DEPTH_WORDS.
- Misaligned when half and addr[0]=1, or word and addr[1:0]!=0.
- Error (misaligned, out-of-range or size 11): no write, rdata_o=0, err_o=1 with rvalid_o.
- Store commit: array written on the edge entering RESP, using the latched request.
  - Byte enables: byte -> 1<<addr[1:0]; half -> 0011<<addr[1:0]; word -> 1111.
  - Write data is replicated across lanes (byte x4, half x2).
  - Only enabled lanes change.
- Load: the word is read on the same edge. rdata_o is the selected lane, extended per unsigned_i; unsigned_i is ignored for word.
- Load issued after a store: returns the new data, since the store has completed before the load is accepted.
- Inputs other than req_i are don't-care when not granted.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and rvalid_o is forced to 0. A store not yet committed is dropped; there is never a partial lane write.
- req_i held high during WAIT or RESP: ignored; it is re-sampled in IDLE.

Decomposition:
- data_mem_pkg:
  - size_e enum (SZ_B, SZ_H, SZ_W).
  - state_e enum (IDLE, WAIT, RESP).
  - Function for byte-enable generation.
- Sub-module data_mem_align (combinational):
  - Store path: produces be[3:0] and replicated wdata.
  - Load path: extracts and sign/zero-extends the load lane.
  - Misalignment flag.
- The top level holds the FSM, the latches and the storage array.

Test Plan:
- WAIT_STATES=0: SW 0x0000_0003 @4, then LW @4 -> gnt_o on the request cycles; rvalid_o one cycle after each accept; rdata_o=0x0000_0003, err_o=0.
- SW 0xAABBCCDD @8, SB 0x11 @9, then LW @8 -> 0xAABB11DD. LB @11 -> 0xFFFFFFAA. LBU @11 -> 0x000000AA. LH @10 -> 0xFFFFAABB.
- SH @6 of 0x1234, then LHU @6 -> 0x00001234. LW @5 -> err_o=1, rdata_o=0, memory at word 1 unchanged.
- Address 4*DEPTH_WORDS with SW -> err_o=1, no wrap-around write to word 0. Same for size 11 -> err_o=1.
- WAIT_STATES=3: LW accepted at cycle N -> rvalid_o only in N+4. req_i held high throughout -> gnt_o only in IDLE cycles, one per 5 cycles.
- WAIT_STATES=3: SW 0xDEADBEEF @12 accepted, rst_n low at N+2 -> rvalid_o=0 immediately; after release, LW @12 returns the prior contents, not 0xDEADBEEF.

Source files
------------

// File: rtl/data_mem_lsu_pkg.sv
// rtl/data_mem_lsu_pkg.sv - shared types and byte-enable helper for the data memory LSU
// Contents: size_e (access size), state_e (FSM state), byte_en() lane-enable function.
package data_mem_lsu_pkg;

  // Encodings match the RV32 funct3[1:0] size field; 2'b11 is deliberately absent.
  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam int LANES = 4;

  // Lane enables for a 32-bit word. Misaligned halves shift partly out of the
  // word; those requests are rejected before the enables are ever used.
  function automatic logic [LANES-1:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    logic [LANES-1:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = 4'b0011 << off;
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/data_mem_lsu_if.sv
// rtl/data_mem_lsu_if.sv - request/grant/response bus between memory stage and LSU
// Signals: req_i, we_i, addr_i, size_i, unsigned_i, wdata_i (requester -> LSU);
//          gnt_o, rvalid_o, rdata_o, err_o (LSU -> requester).
// Modports: master (requester side), slave (LSU side).
interface data_mem_lsu_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
);
  logic              req_i;
  logic              we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [1:0]        size_i;
  logic              unsigned_i;
  logic [DATA_W-1:0] wdata_i;
  logic              gnt_o;
  logic              rvalid_o;
  logic [DATA_W-1:0] rdata_o;
  logic              err_o;

  modport master (
    output req_i, we_i, addr_i, size_i, unsigned_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, size_i, unsigned_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/data_mem_lsu_align.sv
// rtl/data_mem_lsu_align.sv - combinational lane alignment for loads and stores
// Inputs:  off (addr[1:0]), size, is_unsigned, wdata (right-justified), rword (stored word)
// Outputs: be (lane enables), wdata_rep (lane-replicated store data),
//          rdata_ext (extended load lane), misaligned, size_bad (size 2'b11)
module data_mem_lsu_align
  import data_mem_lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned,
  output logic        size_bad
);

  logic [31:0] lane;

  always_comb begin
    be        = byte_en(size, off);
    wdata_rep = wdata;
    rdata_ext = rword;
    lane      = rword >> {off, 3'b000};

    // Replicating store data means the enabled lanes always see the right bytes
    // without a separate shifter on the write path.
    case (size)
      SZ_B:    wdata_rep = {4{wdata[7:0]}};
      SZ_H:    wdata_rep = {2{wdata[15:0]}};
      default: wdata_rep = wdata;
    endcase

    case (size)
      SZ_B:    rdata_ext = is_unsigned ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      SZ_H:    rdata_ext = is_unsigned ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: rdata_ext = rword;
    endcase

    misaligned = ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'b00));
    size_bad   = (size == 2'b11);
  end

endmodule

// File: rtl/data_mem_lsu.sv
// rtl/data_mem_lsu.sv - word-organised data memory with RV32 load/store sizing and wait states
// Ports: clk, rst_n (async, active-low), bus (data_mem_lsu_if.slave: req/gnt handshake,
//        one-cycle rvalid_o response carrying rdata_o and err_o).
// Parameters: ADDR_W byte-address width, DATA_W (must be 32), DEPTH_WORDS, WAIT_STATES (0..15).
module data_mem_lsu
  import data_mem_lsu_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  data_mem_lsu_if.slave bus
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH_WORDS);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  if (DATA_W != 32) begin : g_bad_data_w
    $error("data_mem_lsu: DATA_W must be 32");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
    $error("data_mem_lsu: WAIT_STATES must be 0..15");
  end

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic              accept;
  logic              enter_resp;

  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [1:0]        cur_size;
  logic              cur_uns;
  logic [DATA_W-1:0] cur_wdata;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic [MEM_AW-1:0] widx;
  logic [DATA_W-1:0] rword;
  logic [3:0]        be;
  logic [DATA_W-1:0] wdata_rep;
  logic [DATA_W-1:0] rdata_ext;
  logic              misaligned;
  logic              size_bad;
  logic              out_of_range;
  logic              req_err;
  logic              mem_we;

  // Gated by rst_n so a request presented during reset is never granted.
  assign accept     = bus.req_i && (state_q == IDLE) && rst_n;
  assign bus.gnt_o  = accept;

  // With no wait states the commit edge is the accept edge, so the live request
  // must be used; otherwise the latched copy is the only valid source.
  assign cur_we    = (state_q == IDLE) ? bus.we_i       : we_q;
  assign cur_addr  = (state_q == IDLE) ? bus.addr_i     : addr_q;
  assign cur_size  = (state_q == IDLE) ? bus.size_i     : size_q;
  assign cur_uns   = (state_q == IDLE) ? bus.unsigned_i : uns_q;
  assign cur_wdata = (state_q == IDLE) ? bus.wdata_i    : wdata_q;

  assign widx         = cur_addr[MEM_AW+1:2];
  assign rword        = mem[widx];
  assign out_of_range = !({1'b0, cur_addr[ADDR_W-1:2]} < DEPTH_L);
  assign req_err      = out_of_range || misaligned || size_bad;
  assign mem_we       = enter_resp && cur_we && !req_err && rst_n;

  data_mem_lsu_align u_align (
    .off         (cur_addr[1:0]),
    .size        (cur_size),
    .is_unsigned (cur_uns),
    .wdata       (cur_wdata),
    .rword       (rword),
    .be          (be),
    .wdata_rep   (wdata_rep),
    .rdata_ext   (rdata_ext),
    .misaligned  (misaligned),
    .size_bad    (size_bad)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WS_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= bus.we_i;
        addr_q  <= bus.addr_i;
        size_q  <= bus.size_i;
        uns_q   <= bus.unsigned_i;
        wdata_q <= bus.wdata_i;
      end
      // Response registers only hold non-zero values during the RESP cycle.
      if (enter_resp) begin
        err_q   <= req_err;
        rdata_q <= (req_err || cur_we) ? '0 : rdata_ext;
      end else begin
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
    end
  end

  // Storage is not reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < LANES; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  assign bus.rvalid_o = (state_q == RESP);
  assign bus.err_o    = err_q;
  assign bus.rdata_o  = rdata_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb/tb_data_mem_lsu.sv - self-checking bench for data_mem_lsu with 0 and 3 wait states
module tb_data_mem_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  logic        req_v [2];
  logic        we_v  [2];
  logic [19:0] addr_v[2];
  logic [1:0]  size_v[2];
  logic        uns_v [2];
  logic [31:0] wd_v  [2];

  logic        gnt_w [2];
  logic        rv_w  [2];
  logic [31:0] rd_w  [2];
  logic        err_w [2];

  data_mem_lsu_if #(.ADDR_W(20), .DATA_W(32)) bus0 ();
  data_mem_lsu_if #(.ADDR_W(20), .DATA_W(32)) bus3 ();

  assign bus0.req_i = req_v[0];  assign bus3.req_i = req_v[1];
  assign bus0.we_i = we_v[0];    assign bus3.we_i = we_v[1];
  assign bus0.addr_i = addr_v[0]; assign bus3.addr_i = addr_v[1];
  assign bus0.size_i = size_v[0]; assign bus3.size_i = size_v[1];
  assign bus0.unsigned_i = uns_v[0]; assign bus3.unsigned_i = uns_v[1];
  assign bus0.wdata_i = wd_v[0]; assign bus3.wdata_i = wd_v[1];
  assign gnt_w[0] = bus0.gnt_o;  assign gnt_w[1] = bus3.gnt_o;
  assign rv_w[0] = bus0.rvalid_o; assign rv_w[1] = bus3.rvalid_o;
  assign rd_w[0] = bus0.rdata_o; assign rd_w[1] = bus3.rdata_o;
  assign err_w[0] = bus0.err_o;  assign err_w[1] = bus3.err_o;

  data_mem_lsu #(.ADDR_W(20), .DATA_W(32), .DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  data_mem_lsu #(.ADDR_W(20), .DATA_W(32), .DEPTH_WORDS(1024), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3));

  // ---------------- behavioural model ----------------
  logic [31:0] mm    [2][1024];
  bit          known [2][1024];
  bit          pend_v[2];
  int          pend_c[2];
  int          free_c[2];
  logic        p_we  [2];
  logic [19:0] p_addr[2];
  logic [1:0]  p_size[2];
  logic        p_uns [2];
  logic [31:0] p_wd  [2];
  int          resp_cnt[2];
  int          base_cnt[2];
  logic        last_err_dut[2];
  logic [31:0] last_rd_dut [2];
  logic        last_err_mod[2];
  logic [31:0] last_rd_mod [2];
  int          last_g_cyc  [2];
  int          last_rv_cyc [2];
  int          gq1[$];

  function automatic int ws_of(int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_exec(int d, output logic e, output logic [31:0] r, output bit rk);
    int a, off, idx;
    logic [31:0] old, mask, v;
    a   = int'(p_addr[d]);
    off = a % 4;
    idx = a / 4;
    e = (p_size[d] == 2'd3) || (p_size[d] == 2'd1 && (a % 2) != 0) ||
        (p_size[d] == 2'd2 && off != 0) || (idx >= 1024);
    r  = 32'h0;
    rk = 1'b1;
    if (!e) begin
      old = mm[d][idx];
      if (p_we[d]) begin
        if (p_size[d] == 2'd2) begin
          mm[d][idx]    = p_wd[d];
          known[d][idx] = 1'b1;
        end else if (known[d][idx]) begin
          mask = (p_size[d] == 2'd0) ? 32'hFF : 32'hFFFF;
          mm[d][idx] = (old & ~(mask << (8 * off))) | ((p_wd[d] & mask) << (8 * off));
        end
      end else if (!known[d][idx]) begin
        rk = 1'b0;
      end else begin
        v = old >> (8 * off);
        if (p_size[d] == 2'd0)      r = p_uns[d] ? (v & 32'hFF)   : {{24{v[7]}}, v[7:0]};
        else if (p_size[d] == 2'd1) r = p_uns[d] ? (v & 32'hFFFF) : {{16{v[15]}}, v[15:0]};
        else                        r = old;
      end
    end
  endtask

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    logic e;
    logic [31:0] r;
    bit rk, exp_g;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        pend_v[d] = 1'b0;
        free_c[d] = 0;
        chk($sformatf("rst_gnt%0d", d), {31'b0, gnt_w[d]}, 32'd0);
        chk($sformatf("rst_rvalid%0d", d), {31'b0, rv_w[d]}, 32'd0);
        chk($sformatf("rst_err%0d", d), {31'b0, err_w[d]}, 32'd0);
        chk($sformatf("rst_rdata%0d", d), rd_w[d], 32'd0);
      end else begin
        if (pend_v[d] && pend_c[d] == cyc) begin
          model_exec(d, e, r, rk);
          chk($sformatf("rvalid%0d@%0d", d, cyc), {31'b0, rv_w[d]}, 32'd1);
          chk($sformatf("err%0d@%0d", d, cyc), {31'b0, err_w[d]}, {31'b0, e});
          if (rk) chk($sformatf("rdata%0d@%0d", d, cyc), rd_w[d], r);
          last_err_dut[d] = err_w[d];
          last_rd_dut[d]  = rd_w[d];
          last_err_mod[d] = e;
          last_rd_mod[d]  = r;
          pend_v[d] = 1'b0;
          resp_cnt[d]++;
        end else begin
          chk($sformatf("idle_rvalid%0d@%0d", d, cyc), {31'b0, rv_w[d]}, 32'd0);
        end
        if (rv_w[d]) last_rv_cyc[d] = cyc;
        exp_g = req_v[d] && (cyc >= free_c[d]);
        chk($sformatf("gnt%0d@%0d", d, cyc), {31'b0, gnt_w[d]}, {31'b0, exp_g});
        if (gnt_w[d]) begin
          last_g_cyc[d] = cyc;
          if (d == 1) gq1.push_back(cyc);
        end
        if (exp_g) begin
          pend_v[d] = 1'b1;
          pend_c[d] = cyc + 1 + ws_of(d);
          free_c[d] = cyc + 2 + ws_of(d);
          p_we[d] = we_v[d]; p_addr[d] = addr_v[d]; p_size[d] = size_v[d];
          p_uns[d] = uns_v[d]; p_wd[d] = wd_v[d];
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(int d, logic we, logic [19:0] a, logic [1:0] sz, logic u, logic [31:0] wd);
    bit got = 1'b0;
    base_cnt[d] = resp_cnt[d];
    req_v[d] = 1'b1; we_v[d] = we; addr_v[d] = a; size_v[d] = sz; uns_v[d] = u; wd_v[d] = wd;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (gnt_w[d] === 1'b1) got = 1'b1;
    end
    n_chk++;
    if (!got) begin
      n_err++;
      $display("FAIL gnt_timeout dut%0d: got no grant expected grant", d);
    end
    @(posedge clk); #1;
    req_v[d] = 1'b0;
  endtask

  task automatic wait_resp(int d);
    bit got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (resp_cnt[d] > base_cnt[d]) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    n_chk++;
    if (!got) begin
      n_err++;
      $display("FAIL resp_timeout dut%0d: got no response expected response", d);
    end
  endtask

  task automatic txn(int d, logic we, logic [19:0] a, logic [1:0] sz, logic u, logic [31:0] wd);
    issue(d, we, a, sz, u, wd);
    wait_resp(d);
  endtask

  task automatic expect_last(string nm, int d, logic e, logic [31:0] r);
    chk({nm, "_err"}, {31'b0, last_err_dut[d]}, {31'b0, e});
    chk({nm, "_rdata"}, last_rd_dut[d], r);
    chk({nm, "_model"}, last_rd_mod[d], r);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_v[d] = 1'b0; we_v[d] = 1'b0; addr_v[d] = '0; size_v[d] = 2'd0;
      uns_v[d] = 1'b0; wd_v[d] = '0; resp_cnt[d] = 0; free_c[d] = 0; pend_v[d] = 1'b0;
    end
    rst_n = 1'b0;
    req_v[0] = 1'b1;                    // must not be granted while in reset
    repeat (3) @(posedge clk);
    #1;
    req_v[0] = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- zero wait states ----
    txn(0, 1, 20'd4, 2'd2, 0, 32'h0000_0003);   expect_last("sw4", 0, 0, 32'h0);
    txn(0, 0, 20'd4, 2'd2, 0, 32'h0);           expect_last("lw4", 0, 0, 32'h0000_0003);
    chk("lat0", last_rv_cyc[0] - last_g_cyc[0], 32'd1);
    txn(0, 1, 20'd8, 2'd2, 0, 32'hAABB_CCDD);
    txn(0, 1, 20'd9, 2'd0, 0, 32'h0000_0011);
    txn(0, 0, 20'd8, 2'd2, 0, 32'h0);           expect_last("lw8", 0, 0, 32'hAABB_11DD);
    txn(0, 0, 20'd11, 2'd0, 0, 32'h0);          expect_last("lb11", 0, 0, 32'hFFFF_FFAA);
    txn(0, 0, 20'd11, 2'd0, 1, 32'h0);          expect_last("lbu11", 0, 0, 32'h0000_00AA);
    txn(0, 0, 20'd10, 2'd1, 0, 32'h0);          expect_last("lh10", 0, 0, 32'hFFFF_AABB);
    txn(0, 1, 20'd6, 2'd1, 0, 32'h0000_1234);
    txn(0, 0, 20'd6, 2'd1, 1, 32'h0);           expect_last("lhu6", 0, 0, 32'h0000_1234);
    txn(0, 0, 20'd5, 2'd2, 0, 32'h0);           expect_last("lw5_mis", 0, 1, 32'h0);
    txn(0, 1, 20'd5, 2'd2, 0, 32'hFFFF_FFFF);   expect_last("sw5_mis", 0, 1, 32'h0);
    txn(0, 0, 20'd9, 2'd1, 0, 32'h0);           expect_last("lh9_mis", 0, 1, 32'h0);
    txn(0, 0, 20'd4, 2'd2, 0, 32'h0);           expect_last("lw4_kept", 0, 0, 32'h1234_0003);
    txn(0, 1, 20'd0, 2'd2, 0, 32'h5A5A_5A5A);
    txn(0, 1, 20'h01000, 2'd2, 0, 32'h7777_7777); expect_last("sw_oor", 0, 1, 32'h0);
    txn(0, 1, 20'd0, 2'd3, 0, 32'h1111_1111);   expect_last("sz3_st", 0, 1, 32'h0);
    txn(0, 0, 20'd0, 2'd2, 0, 32'h0);           expect_last("lw0_nowrap", 0, 0, 32'h5A5A_5A5A);
    txn(0, 0, 20'd0, 2'd3, 0, 32'h0);           expect_last("sz3_ld", 0, 1, 32'h0);
    txn(0, 1, 20'd3, 2'd0, 0, 32'h0000_0080);
    txn(0, 0, 20'd3, 2'd0, 0, 32'h0);           expect_last("lb3", 0, 0, 32'hFFFF_FF80);
    txn(0, 1, 20'h00FFC, 2'd2, 0, 32'hCAFE_F00D);
    txn(0, 0, 20'h00FFE, 2'd1, 1, 32'h0);       expect_last("lhu_top", 0, 0, 32'h0000_CAFE);

    // ---- three wait states ----
    txn(1, 1, 20'd12, 2'd2, 0, 32'h0102_0304);
    txn(1, 0, 20'd12, 2'd2, 0, 32'h0);          expect_last("ws3_lw12", 1, 0, 32'h0102_0304);
    chk("lat3", last_rv_cyc[1] - last_g_cyc[1], 32'd4);

    gq1.delete();
    req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = 20'd12; size_v[1] = 2'd2; uns_v[1] = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    req_v[1] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("thru_count", gq1.size(), 32'd4);
    for (int i = 1; i < gq1.size(); i++) chk($sformatf("thru_gap%0d", i), gq1[i] - gq1[i-1], 32'd5);

    issue(1, 1, 20'd12, 2'd2, 0, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_rvalid", {31'b0, rv_w[1]}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn(1, 0, 20'd12, 2'd2, 0, 32'h0);          expect_last("rst_drop", 1, 0, 32'h0102_0304);
    txn(0, 0, 20'd4, 2'd2, 0, 32'h0);           expect_last("rst_keep0", 0, 0, 32'h1234_0003);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
